status_value_vector: RTL and testbench

//  Ordered status queue: holds up to DEPTH WIDTH-bit status values in arrival order.

---
 rtl/status_value_vector_pkg.sv | 21 ++
 rtl/svv_ptr.sv | 42 ++++
 rtl/status_value_vector.sv | 100 ++++++++++
 tb/tb_status_value_vector.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/status_value_vector_pkg.sv
// Shared defaults and helpers for the status value vector.
// Holds default geometry and a portable clog2 for flows without $clog2.
package status_value_vector_pkg;

  localparam int SVV_DEPTH = 32;
  localparam int SVV_WIDTH = 4;

  // Smallest n with 2**n >= value; 0 for value <= 1.
  function automatic int svv_clog2(input int value);
    int n;
    int v;
    n = 0;
    v = 1;
    while (v < value) begin
      v = v * 2;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/svv_ptr.sv
// Wrap-around pointer register for the status value vector.
// Ports: clk_i, rsn_i (sync, active-low), en_i (advance), ptr_o (current).
module svv_ptr
  import status_value_vector_pkg::*;
#(
  parameter int DEPTH = SVV_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rsn_i,
  input  logic          en_i,
  output logic [PW-1:0] ptr_o
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // Explicit wrap so non power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) begin
      if (ptr_q == LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/status_value_vector.sv
// Ordered status queue: DEPTH entries of WIDTH bits, oldest shown on value_o.
// Ports: clk_i, rsn_i (sync, active-low), push_i, pull_i, value_i,
//        value_o (oldest or 0), valid_o (non-empty), full_o (DEPTH stored).
module status_value_vector
  import status_value_vector_pkg::*;
#(
  parameter int DEPTH = SVV_DEPTH,
  parameter int WIDTH = SVV_WIDTH
) (
  input  logic             clk_i,
  input  logic             rsn_i,
  input  logic             push_i,
  input  logic             pull_i,
  input  logic [WIDTH-1:0] value_i,
  output logic [WIDTH-1:0] value_o,
  output logic             valid_o,
  output logic             full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] vld_d;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pull_ok;
  logic             push_ok;

  // Outputs depend on registered state only.
  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign value_o = valid_o ? mem_q[rd_ptr] : '0;

  // A pull frees a slot this same edge, so a full queue
  // can still take a push when it is also being pulled.
  assign pull_ok = pull_i & valid_o;
  assign push_ok = push_i & (~full_o | pull_ok);

  svv_ptr #(
    .DEPTH (DEPTH)
  ) u_rd_ptr (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .en_i  (pull_ok),
    .ptr_o (rd_ptr)
  );

  svv_ptr #(
    .DEPTH (DEPTH)
  ) u_wr_ptr (
    .clk_i (clk_i),
    .rsn_i (rsn_i),
    .en_i  (push_ok),
    .ptr_o (wr_ptr)
  );

  // Clear before set: when full, rd_ptr == wr_ptr and the
  // slot must end up valid holding the new value.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    if (pull_ok) begin
      vld_d[rd_ptr] = 1'b0;
    end
    if (push_ok) begin
      mem_d[wr_ptr] = value_i;
      vld_d[wr_ptr] = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      push_ok & ~pull_ok: count_d = count_q + 1'b1;
      pull_ok & ~push_ok: count_d = count_q - 1'b1;
      default:            count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      vld_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      vld_q   <= vld_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_status_value_vector.sv
// Self-checking bench for status_value_vector against a queue model.
// Directed scenarios plus randomized push/pull/reset traffic.
module tb_status_value_vector;

  localparam int DEPTH = 32;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rsn_i = 1'b0;
  logic             push_i = 1'b0;
  logic             pull_i = 1'b0;
  logic [WIDTH-1:0] value_i = '0;
  logic [WIDTH-1:0] value_o;
  logic             valid_o;
  logic             full_o;

  int vectors = 0;
  int miscompares = 0;
  int q[$];

  always #5 clk = ~clk;

  status_value_vector #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) dut (
    .clk_i   (clk),
    .rsn_i   (rsn_i),
    .push_i  (push_i),
    .pull_i  (pull_i),
    .value_i (value_i),
    .value_o (value_o),
    .valid_o (valid_o),
    .full_o  (full_o)
  );

  // Expected {valid, full, value} from the model queue.
  function automatic logic [WIDTH+1:0] exp_out();
    logic [WIDTH-1:0] v;
    v = (q.size() != 0) ? WIDTH'(q[0]) : '0;
    return {q.size() != 0, q.size() == DEPTH, v};
  endfunction

  // Drive one cycle, advance the model, settle past the edge.
  task automatic step(input bit rst, input bit ps, input bit pl,
                      input logic [WIDTH-1:0] v);
    bit pok;
    bit sok;
    @(negedge clk);
    rsn_i   = ~rst;
    push_i  = ps;
    pull_i  = pl;
    value_i = v;
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      pok = pl && (q.size() != 0);
      sok = ps && ((q.size() < DEPTH) || pok);
      if (pok) void'(q.pop_front());
      if (sok) q.push_back(int'(v));
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0, '0);
      vectors++;
      if ({valid_o, full_o, value_o} !== {1'b0, 1'b0, 4'h0}) begin
        miscompares++;
        $display("FAIL reset[%0d]: got v=%b f=%b val=%h, want 0 0 0",
                 i, valid_o, full_o, value_o);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 1'b1, 1'b0, WIDTH'(i));
      vectors++;
      if ({valid_o, full_o, value_o} !== {1'b1, 1'b0, 4'h1}) begin
        miscompares++;
        $display("FAIL fill[%0d]: got v=%b f=%b val=%h, want 1 0 1",
                 i, valid_o, full_o, value_o);
      end
    end
  endtask

  task automatic test_drain_empty();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      vectors++;
      if ({valid_o, full_o, value_o} !== exp_out()) begin
        miscompares++;
        $display("FAIL drain[%0d]: got %b_%b_%h, want %b", i,
                 valid_o, full_o, value_o, exp_out());
      end
    end
    vectors++;
    if ({valid_o, value_o} !== 5'b0_0000) begin
      miscompares++;
      $display("FAIL drain_end: got v=%b val=%h, want 0 0", valid_o, value_o);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 33; i++) begin
      step(1'b0, 1'b1, 1'b0, WIDTH'(i));
      vectors++;
      if (full_o !== (i >= 32) || value_o !== 4'h1 || valid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL ovf[%0d]: got f=%b v=%b val=%h, want f=%b 1 1",
                 i, full_o, valid_o, value_o, i >= 32);
      end
    end
  endtask

  task automatic test_full_pushpull();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, WIDTH'(4'hA + i));
      vectors++;
      if (full_o !== 1'b1 || value_o !== WIDTH'(i + 2)) begin
        miscompares++;
        $display("FAIL fullpp[%0d]: got f=%b val=%h, want 1 %h",
                 i, full_o, value_o, WIDTH'(i + 2));
      end
    end
    // Drain: values 4..32 (mod 16), then A, B, C.
    for (int i = 0; i < DEPTH; i++) begin
      logic [WIDTH-1:0] want;
      want = (i < 29) ? WIDTH'(i + 4) : WIDTH'(4'hA + i - 29);
      vectors++;
      if (value_o !== want || valid_o !== 1'b1) begin
        miscompares++;
        $display("FAIL fulldrain[%0d]: got v=%b val=%h, want 1 %h",
                 i, valid_o, value_o, want);
      end
      step(1'b0, 1'b0, 1'b1, '0);
    end
    vectors++;
    if (valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL fulldrain_end: got v=%b, want 0", valid_o);
    end
  endtask

  task automatic test_empty_pushpull_reset();
    step(1'b0, 1'b1, 1'b1, 4'h9);
    vectors++;
    if ({valid_o, full_o, value_o} !== {1'b1, 1'b0, 4'h9}) begin
      miscompares++;
      $display("FAIL emptypp: got %b_%b_%h, want 1_0_9",
               valid_o, full_o, value_o);
    end
    step(1'b0, 1'b1, 1'b0, 4'h3);
    step(1'b1, 1'b1, 1'b1, 4'h5);
    vectors++;
    if ({valid_o, full_o, value_o} !== {1'b0, 1'b0, 4'h0}) begin
      miscompares++;
      $display("FAIL midreset: got %b_%b_%h, want 0_0_0",
               valid_o, full_o, value_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bit rst;
      bit ps;
      bit pl;
      int phase;
      phase = (i / 150) % 3;
      rst = ($urandom_range(0, 199) == 0);
      ps = ($urandom_range(0, 9) < (phase == 0 ? 8 : (phase == 1 ? 3 : 5)));
      pl = ($urandom_range(0, 9) < (phase == 0 ? 2 : (phase == 1 ? 7 : 5)));
      step(rst, ps, pl, WIDTH'($urandom));
      vectors++;
      if ({valid_o, full_o, value_o} !== exp_out()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %b_%b_%h, want %b", i,
                 valid_o, full_o, value_o, exp_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_empty();
    test_overflow();
    test_full_pushpull();
    test_empty_pushpull_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
